// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage: walks pc through a synchronous ROM,
// resolves JUMP/HALT locally and issues instructions over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [7:0]            mem_data,
  output logic [7:0]            instr,
  output logic [4:0]            operand,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPFETCH,
    S_OPDECODE,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [7:0]            instr_q, instr_n;
  logic [4:0]            operand_q, operand_n;
  logic                  halted_q, halted_n;

  assign pc_inc = pc + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr_q   <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_q   <= instr_n;
      operand_q <= operand_n;
      halted_q  <= halted_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = instr_q;
    operand_n = operand_q;
    halted_n  = halted_q;
    case (state)
      S_IDLE: begin
        pc_n = '0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH:   state_n = S_DECODE;
      S_DECODE: begin
        instr_n = mem_data;
        if (mem_data[7:5] == 3'd7) begin
          if (mem_data[4]) begin
            halted_n = 1'b1;
            state_n  = S_HALT;
          end else begin
            // jump target is zero-extended from the low nibble
            pc_n      = '0;
            pc_n[3:0] = mem_data[3:0];
            state_n   = S_FETCH;
          end
        end else if (mem_data[7:5] == 3'd6) begin
          pc_n    = pc_inc;
          state_n = S_OPFETCH;
        end else begin
          operand_n = mem_data[4:0];
          pc_n      = pc_inc;
          state_n   = S_ISSUE;
        end
      end
      S_OPFETCH: state_n = S_OPDECODE;
      S_OPDECODE: begin
        operand_n = mem_data[4:0];
        pc_n      = pc_inc;
        state_n   = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_ready) state_n = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_n     = '0;
          halted_n = 1'b0;
          state_n  = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_addr    = pc;
  assign mem_en      = (state == S_FETCH) || (state == S_OPFETCH);
  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign instr       = instr_q;
  assign operand     = operand_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program-level model predicts the issue stream,
// issue cycles and final pc; directed programs plus random terminating programs.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mem_addr;
  logic       mem_en;
  logic [7:0] mem_data;
  logic [7:0] instr;
  logic [4:0] operand;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       halted;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rom [16];

  logic [7:0] exp_instr [$];
  logic [4:0] exp_op [$];
  int         exp_cyc [$];
  int         exp_npc [$];
  bit         exp_halt;
  int         exp_pc;

  instr_fetch #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .instr(instr), .operand(operand),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data appears the cycle after an enabled edge
  always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the program from address 0; cycle 1 is the first FETCH after start.
  function automatic void model(input int max_issue);
    int pc;
    int c;
    int steps;
    logic [7:0] b;
    pc = 0; c = 1; steps = 0;
    exp_instr.delete(); exp_op.delete(); exp_cyc.delete(); exp_npc.delete();
    exp_halt = 1'b0; exp_pc = 0;
    while (steps < 200 && exp_instr.size() < max_issue) begin
      b = rom[pc];
      steps++;
      if (b[7:5] == 3'd7) begin
        if (b[4]) begin
          exp_halt = 1'b1;
          exp_pc = pc;
          break;
        end
        pc = int'(b[3:0]);
        c += 2;
      end else if (b[7:5] == 3'd6) begin
        exp_instr.push_back(b);
        exp_op.push_back(rom[(pc + 1) % 16][4:0]);
        exp_cyc.push_back(c + 4);
        pc = (pc + 2) % 16;
        exp_npc.push_back(pc);
        c += 5;
      end else begin
        exp_instr.push_back(b);
        exp_op.push_back(b[4:0]);
        exp_cyc.push_back(c + 2);
        pc = (pc + 1) % 16;
        exp_npc.push_back(pc);
        c += 3;
      end
    end
  endfunction

  function automatic void gen_prog();
    int a;
    int t;
    int k;
    a = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    while (a < 15) begin
      k = $urandom_range(0, 2);
      if (k == 1 && a < 14) begin
        rom[a] = {3'b110, 5'($urandom)};
        a += 2;
      end else if (k == 2) begin
        t = $urandom_range(a + 1, 15);
        rom[a] = {4'b1110, 4'(t)};
        a = t;
      end else begin
        rom[a] = {3'($urandom_range(0, 5)), 5'($urandom)};
        a++;
      end
    end
    rom[15] = {4'b1111, 4'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_operand", 32'(operand), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Start the program and follow it until halt or max_issue transfers.
  task automatic run(input int max_issue, input bit rnd);
    int cyc;
    int n;
    int n_exp;
    int npc;
    bit held;
    bit check_fetch;
    logic [7:0] hi;
    logic [4:0] ho;
    cyc = 1; n = 0; npc = 0; held = 0; check_fetch = 0; hi = '0; ho = '0;
    model(max_issue);
    n_exp = exp_instr.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_fetch_en", 32'(mem_en), 1);
    chk("first_fetch_addr", 32'(mem_addr), 0);
    forever begin
      start = 1'b0;
      if (check_fetch) begin
        chk("next_fetch_en", 32'(mem_en), 1);
        chk("next_fetch_addr", 32'(mem_addr), 32'(npc));
        check_fetch = 0;
      end
      if (held) begin
        chk("stall_valid", 32'(instr_valid), 1);
        chk("stall_instr", 32'(instr), 32'(hi));
        chk("stall_operand", 32'(operand), 32'(ho));
      end
      if (halted) break;
      if (n >= max_issue) break;
      instr_ready = rnd ? 1'($urandom) : 1'b1;
      if (rnd && busy) start = 1'($urandom);
      if (instr_valid && instr_ready) begin
        if (exp_instr.size() == 0) begin
          chk("unexpected_issue", 32'(instr), 32'hffff_ffff);
        end else begin
          chk("issue_instr", 32'(instr), 32'(exp_instr.pop_front()));
          chk("issue_operand", 32'(operand), 32'(exp_op.pop_front()));
          if (!rnd) chk("issue_cycle", 32'(cyc), 32'(exp_cyc[0]));
          void'(exp_cyc.pop_front());
          npc = exp_npc.pop_front();
          check_fetch = 1;
        end
        n++;
        held = 0;
      end else if (instr_valid) begin
        held = 1;
        hi = instr;
        ho = operand;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk("run_timeout", 32'(cyc), 3000);
        break;
      end
    end
    start = 1'b0;
    instr_ready = 1'b0;
    chk("issue_count", 32'(n), 32'(n_exp));
    chk("halted_state", 32'(halted), 32'(exp_halt));
    if (exp_halt) begin
      chk("halt_busy", 32'(busy), 0);
      chk("halt_pc", 32'(mem_addr), 32'(exp_pc));
    end
  endtask

  initial begin
    int w;
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;

    // reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;

    // basic sequence, then restart from HALT without reset
    rom[0] = 8'h01; rom[1] = 8'h23; rom[2] = 8'hF0;
    run(50, 0);
    run(50, 0);

    // two-byte LOAD
    do_reset();
    rom[0] = 8'hC0; rom[1] = 8'h1A; rom[2] = 8'hF0;
    run(50, 0);

    // JUMP to 5
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    rom[0] = 8'hE5; rom[5] = 8'h42; rom[6] = 8'hF0;
    run(50, 0);

    // backpressure: ready low for 6 ISSUE cycles
    do_reset();
    rom[0] = 8'h45; rom[1] = 8'hF0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!instr_valid && w < 20) begin @(negedge clk); w++; end
    chk("bp_reach_issue", 32'(instr_valid), 1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_instr", 32'(instr), 32'h45);
      chk("bp_operand", 32'(operand), 32'h05);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("bp_after_valid", 32'(instr_valid), 0);
    chk("bp_after_fetch", 32'(mem_en), 1);
    chk("bp_after_addr", 32'(mem_addr), 1);
    w = 0;
    while (!halted && w < 20) begin @(negedge clk); w++; end
    chk("bp_halted", 32'(halted), 1);

    // wrap: single-byte at 15 falls through to 0
    do_reset();
    for (int i = 0; i < 15; i++) rom[i] = 8'(i + 1);
    rom[15] = 8'h07;
    run(17, 0);

    // wrap: LOAD at 15 takes operand from 0
    do_reset();
    rom[0] = 8'h11;
    rom[15] = 8'hC0;
    run(17, 0);

    // reset during a stalled ISSUE, then resume
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    rom[0] = 8'h01; rom[1] = 8'h23; rom[2] = 8'hF0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!instr_valid && w < 20) begin @(negedge clk); w++; end
    chk("mid_reach_issue", 32'(instr_valid), 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;
    run(50, 0);

    // random terminating programs, half with random ready and stray start
    for (int p = 0; p < 24; p++) begin
      if ((p % 4) == 0) do_reset();
      gen_prog();
      run(50, p[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
